mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single program/data memory port between two requesters: requester 0 = control unit (fetch/execute accesses), requester 1 = loader/DMA (program download, debug reads/writes).
- Arbitrates per transaction and sequences the memory control strobes (ce, r, oe, w) with the same two-phase read and single-phase write timing the control unit uses.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req0 / req1  in  1  transaction request, held until ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_W  transaction address; stable while req is high.
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  read result, valid while ackN=1 and held until that requester's next read completes.
- gnt  out  2  one-hot current owner, 00 when idle.
- mem_ce, mem_r, mem_oe, mem_w  out  1 each  memory strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - All strobes, ack0/1, gnt, mem_addr, mem_wdata = 0.
  - rdata0/1 = 0.
  - last-grant pointer = 1, so requester 0 wins the first conflict.
  - Reset mid-transaction aborts it immediately; no ack is issued.
- All outputs are registered.
- States: IDLE, RD_ADDR, RD_DATA, WR, ACK.
- IDLE:
  - No request: stay in IDLE, all strobes 0.
  - Single request: grant it.
  - Both requesting: grant the requester not equal to the last-grant pointer.
  - On grant: latch owner, we, addr and wdata into internal registers; update the pointer; set gnt. Go to WR if we=1, else RD_ADDR.
- RD_ADDR (one cycle): mem_ce=1, mem_r=1, mem_addr=latched addr → RD_DATA.
- RD_DATA (one cycle): mem_ce=1, mem_oe=1, mem_addr held. At the closing posedge, capture mem_rdata into the owner's rdata register → ACK.
- WR (one cycle): mem_ce=1, mem_w=1, mem_addr and mem_wdata driven → ACK.
- ACK (one cycle):
  - All strobes 0; ack of owner = 1; gnt still shows owner.
  - Requests are ignored in this state → IDLE, gnt cleared.
- Latency from the req-sampled edge:
  - Read: strobes in cycles +1 and +2, ack in cycle +3.
  - Write: strobe in cycle +1, ack in cycle +2.
- Minimum spacing: back-to-back grants are 4 cycles apart for reads and 3 for writes.
- Requester rule: on the edge where it samples ackN=1, the requester either drops reqN or presents its next transaction. The arbiter samples again only in IDLE.
- Fairness: round-robin guarantees a continuously requesting requester waits at most one foreign transaction.
- Request dropped mid-transaction: the latched transaction completes and ack still pulses. The requester's inputs are not re-sampled.
- Request changed mid-transaction: addr/we/wdata changes after the grant edge have no effect.
- The non-owner's rdata and ack are unaffected by any transaction it does not own.
- mem_r/mem_oe and mem_w are never both 1; exactly one ack bit at most is 1 in any cycle.

Optional Feature:
- Macro ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. Requester 0 always wins a conflict and the last-grant pointer is unused (the same pointer logic may remain but is ignored). Requester 1 can starve while req0 is held continuously.
- Undefined: round-robin as above.
- Timing and protocol are identical either way.

Test Plan:
- Single read: req0=1, we0=0, addr0=16'h0010, mem returns 8'hA5. Expect mem_ce+mem_r at cycle +1, mem_ce+mem_oe at +2, ack0=1 with rdata0=8'hA5 at +3, gnt=01 during cycles +1..+3.
- Single write: req1=1, we1=1, addr1=16'h1234, wdata1=8'h3C. Expect mem_w=1 with mem_addr=16'h1234 and mem_wdata=8'h3C at +1, ack1 at +2, ack0 never set.
- Conflict round-robin: after reset, req0 and req1 both held continuously with reads. Expect grant order 0,1,0,1 with acks every 4 cycles alternating. With ARB_CPU_PRIORITY_EN, expect only ack0.
- Back-to-back: req0 kept high through ack with a new addr. Expect the next RD_ADDR exactly 2 cycles after ack (ACK→IDLE→RD_ADDR).
- Reset mid-read: assert rst_n=0 during RD_DATA. Expect all strobes, gnt and ack = 0 at the next edge, no ack issued, and the first conflict after release granted to requester 0.
- Request dropped: req1 dropped during RD_ADDR. Expect the transaction to complete, ack1 to pulse at +3, and mem_addr to be unaffected by addr1 changes.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester memory port arbiter with read/write strobe sequencing
// Optional ARB_CPU_PRIORITY_EN: requester 0 wins every conflict instead of round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              mem_ce,
  output logic              mem_r,
  output logic              mem_oe,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, ACK} state_t;

  state_t            state;
  logic              owner;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_CPU_PRIORITY_EN
  assign pick = ~req0;
`else
  // Pointer holds the last winner; the other requester wins the next conflict.
  logic last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last <= pick;
    end
  end

  assign pick = (req0 && req1) ? ~last : req1;
`endif

  assign sel_we    = pick ? we1 : we0;
  assign sel_addr  = pick ? addr1 : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      gnt       <= 2'b00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_ce    <= 1'b0;
      mem_r     <= 1'b0;
      mem_oe    <= 1'b0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            gnt      <= pick ? 2'b10 : 2'b01;
            mem_ce   <= 1'b1;
            mem_addr <= sel_addr;
            if (sel_we) begin
              mem_w     <= 1'b1;
              mem_wdata <= sel_wdata;
              state     <= WR;
            end else begin
              mem_r <= 1'b1;
              state <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          mem_r  <= 1'b0;
          mem_oe <= 1'b1;
          state  <= RD_DATA;
        end
        RD_DATA: begin
          mem_ce <= 1'b0;
          mem_oe <= 1'b0;
          if (owner) begin
            rdata1 <= mem_rdata;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= mem_rdata;
            ack0   <= 1'b1;
          end
          state <= ACK;
        end
        WR: begin
          mem_ce <= 1'b0;
          mem_w  <= 1'b0;
          if (owner) ack1 <= 1'b1;
          else       ack0 <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt   <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
// Transaction-level model schedules expected per-cycle outputs from each grant decision.
module tb_mem_bus_arbiter;

`ifdef ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1, we0, we1, ack0, ack1;
  logic [15:0] addr0, addr1, mem_addr;
  logic [7:0]  wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic [1:0]  gnt;
  logic        mem_ce, mem_r, mem_oe, mem_w;

  logic [1:0]  r_req, r_we;
  logic [15:0] r_addr [2];
  logic [7:0]  r_wdata [2];

  assign req0 = r_req[0];
  assign req1 = r_req[1];
  assign we0 = r_we[0];
  assign we1 = r_we[1];
  assign addr0 = r_addr[0];
  assign addr1 = r_addr[1];
  assign wdata0 = r_wdata[0];
  assign wdata1 = r_wdata[1];

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .gnt(gnt),
    .mem_ce(mem_ce), .mem_r(mem_r), .mem_oe(mem_oe), .mem_w(mem_w),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] pat(int i);
    return 8'hA5 ^ 8'(i * 29);
  endfunction

  // 16-entry memory device aliased on the low address nibble; reloads its pattern on reset.
  logic [7:0] mem [16];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 16; i++) mem[i] <= pat(i);
    else if (mem_ce && mem_w) mem[mem_addr[3:0]] <= mem_wdata;
  end

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        ce, r, oe, w, rd_set;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd;
  } slot_t;

  slot_t      slots [8];
  logic [7:0] mm [16];
  logic [7:0] m_rd [2];
  logic [1:0] inflight, got_ack;
  int         cyc = 0, free = 0, last = 1;
  int         total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: decide the grant the arbiter must make at this edge, then check the cycle after it.
  task automatic step();
    int p, w;
    slot_t e;
    p = cyc;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) slots[i] = '0;
      for (int i = 0; i < 16; i++) mm[i] = pat(i);
      free = p + 1;
      last = 1;
      m_rd[0] = '0;
      m_rd[1] = '0;
      inflight = '0;
    end else if (p >= free && r_req != 2'b00) begin
      if (r_req == 2'b11) w = PRIO ? 0 : ((last == 1) ? 0 : 1);
      else w = r_req[0] ? 0 : 1;
      last = w;
      inflight[w] = 1'b1;
      e = '0;
      e.gnt = (w == 0) ? 2'b01 : 2'b10;
      e.ce = 1'b1;
      e.addr = r_addr[w];
      if (r_we[w]) begin
        e.w = 1'b1;
        e.wdata = r_wdata[w];
        slots[p % 8] = e;
        e = '0;
        e.gnt = (w == 0) ? 2'b01 : 2'b10;
        e.ack[w] = 1'b1;
        slots[(p + 1) % 8] = e;
        mm[r_addr[w][3:0]] = r_wdata[w];
        free = p + 3;
      end else begin
        e.r = 1'b1;
        slots[p % 8] = e;
        e.r = 1'b0;
        e.oe = 1'b1;
        slots[(p + 1) % 8] = e;
        e = '0;
        e.gnt = (w == 0) ? 2'b01 : 2'b10;
        e.ack[w] = 1'b1;
        e.rd_set = 1'b1;
        e.rd = mm[r_addr[w][3:0]];
        slots[(p + 2) % 8] = e;
        free = p + 4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    e = slots[p % 8];
    slots[p % 8] = '0;
    if (e.rd_set) m_rd[e.ack[0] ? 0 : 1] = e.rd;
    chk("gnt", 32'(gnt), 32'(e.gnt));
    chk("ack0", 32'(ack0), 32'(e.ack[0]));
    chk("ack1", 32'(ack1), 32'(e.ack[1]));
    chk("mem_ce", 32'(mem_ce), 32'(e.ce));
    chk("mem_r", 32'(mem_r), 32'(e.r));
    chk("mem_oe", 32'(mem_oe), 32'(e.oe));
    chk("mem_w", 32'(mem_w), 32'(e.w));
    if (e.ce) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
    if (e.w) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
    chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
    chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
    got_ack = e.ack;
    inflight = inflight & ~e.ack;
  endtask

  task automatic run_until_ack(int who, int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!got_ack[who] && n < budget);
  endtask

  task automatic new_txn(int i);
    r_req[i] = 1'b1;
    r_we[i] = 1'($urandom_range(1));
    r_addr[i] = 16'($urandom);
    r_wdata[i] = 8'($urandom);
  endtask

  initial begin
    int t0, n0, n1;
    rst_n = 1'b0;
    r_req = '0;
    r_we = '0;
    r_addr[0] = '0;
    r_addr[1] = '0;
    r_wdata[0] = '0;
    r_wdata[1] = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    inflight = '0;
    got_ack = '0;
    for (int i = 0; i < 8; i++) slots[i] = '0;
    repeat (3) step();
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // single read from 0x0010 (memory pattern gives A5 there)
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 16'h0010;
    t0 = cyc;
    run_until_ack(0, 10);
    chk("rd_latency", 32'(cyc - t0), 32'd3);
    chk("rd_value", 32'(rdata0), 32'hA5);
    r_req[0] = 1'b0;
    repeat (2) step();

    // single write
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 16'h1234; r_wdata[1] = 8'h3C;
    t0 = cyc;
    run_until_ack(1, 10);
    chk("wr_latency", 32'(cyc - t0), 32'd2);
    r_req[1] = 1'b0;
    step();
    chk("wr_mem", 32'(mem[4]), 32'h3C);

    // conflict straight after reset, both holding reads
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    r_req = 2'b11; r_we = 2'b00; r_addr[0] = 16'h0020; r_addr[1] = 16'h0031;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      n0 += int'(ack0);
      n1 += int'(ack1);
    end
    chk("conflict_ack0", 32'(n0), PRIO ? 32'd4 : 32'd2);
    chk("conflict_ack1", 32'(n1), PRIO ? 32'd0 : 32'd2);
    r_req = 2'b00;
    repeat (4) step();

    // back-to-back read with a new address presented on ack
    r_req[0] = 1'b1; r_addr[0] = 16'h0003;
    run_until_ack(0, 10);
    r_addr[0] = 16'h0007;
    repeat (2) step();
    chk("b2b_mem_r", 32'(mem_r), 32'd1);
    chk("b2b_addr", 32'(mem_addr), 32'h0007);
    run_until_ack(0, 10);
    r_req[0] = 1'b0;
    step();

    // reset during RD_DATA, then a conflict must go to requester 0
    r_req[0] = 1'b1; r_addr[0] = 16'h0005;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_ack", 32'({ack1, ack0}), 32'h0);
    chk("midrst_strobes", 32'({mem_ce, mem_r, mem_oe, mem_w}), 32'h0);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0009;
    step();
    chk("postrst_gnt", 32'(gnt), 32'h1);
    run_until_ack(0, 10);
    r_req[0] = 1'b0;
    run_until_ack(1, 10);
    r_req[1] = 1'b0;
    repeat (2) step();

    // request dropped and address changed right after the grant edge
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0042;
    step();
    t0 = cyc - 1;
    r_req[1] = 1'b0; r_addr[1] = 16'h00FF;
    run_until_ack(1, 10);
    chk("drop_latency", 32'(cyc - t0), 32'd3);
    step();

    // randomized traffic with mid-transaction input scrambling and drops
    for (int k = 0; k < 800; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (got_ack[i] && r_req[i]) begin
          if ($urandom_range(1) == 1) new_txn(i);
          else r_req[i] = 1'b0;
        end else if (!r_req[i]) begin
          if ($urandom_range(2) == 0) new_txn(i);
        end else if (inflight[i]) begin
          if ($urandom_range(7) == 0) begin
            r_we[i] = 1'($urandom_range(1));
            r_addr[i] = 16'($urandom);
            r_wdata[i] = 8'($urandom);
          end
          if ($urandom_range(9) == 0) r_req[i] = 1'b0;
        end
      end
    end
    r_req = 2'b00;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
